// File: rtl/mnk_game_engine_if.sv
// Move handshake and game-result bundle for mnk_game_engine.
// The master side offers moves. The slave side (the engine) reports each
// move's outcome and the overall game state.
interface mnk_game_engine_if #(
    parameter int N       = 5,
    parameter int PLAYERS = 2
);
    localparam int CW = $clog2(N);
    localparam int PW = $clog2(PLAYERS + 1);

    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_x;
    logic [CW-1:0] in_y;
    logic [PW-1:0] in_player;
    logic          move_done;
    logic          move_err;
    logic [1:0]    err_code;
    logic [PW-1:0] winner;
    logic          stop_game;

    modport master (
        output in_valid, in_x, in_y, in_player,
        input  in_ready, move_done, move_err, err_code, winner, stop_game
    );

    modport slave (
        input  in_valid, in_x, in_y, in_player,
        output in_ready, move_done, move_err, err_code, winner, stop_game
    );
endinterface

// File: rtl/mnk_game_engine.sv
// Generalised m,n,k game engine: an N x N board, K in a row wins, and PLAYERS
// players take turns in a fixed rotation.
// After each accepted move, a sequential scanner walks only the lines that
// pass through the placed cell, one cell per cycle, in both senses of each of
// the four directions. This keeps the win logic small for large boards.
module mnk_game_engine #(
    parameter int N       = 5,
    parameter int K       = 4,
    parameter int PLAYERS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         clear,
    mnk_game_engine_if.slave             bus,
    input  logic [$clog2(N)-1:0]         rd_x,
    input  logic [$clog2(N)-1:0]         rd_y,
    output logic [$clog2(PLAYERS+1)-1:0] rd_cell
);
    localparam int CW = $clog2(N);
    localparam int PW = $clog2(PLAYERS + 1);
    localparam int RW = $clog2(K + 1);
    localparam int MW = $clog2(N * N + 1);
    localparam int SW = CW + 2;
    localparam logic [PW-1:0]        EMPTY       = {PW{1'b1}};
    localparam logic [PW-1:0]        LAST_PLAYER = PW'(PLAYERS - 1);
    localparam logic [CW:0]          N_U         = (CW + 1)'(N);
    localparam logic signed [SW-1:0] N_S         = SW'(N);
    localparam logic [RW-1:0]        RUN_K       = RW'(K);
    localparam logic [MW-1:0]        CELLS       = MW'(N * N);

    typedef enum logic [1:0] {IDLE, SCAN_POS, SCAN_NEG, RESP} state_t;

    state_t state, next_state;

    logic [PW-1:0]        board [N][N];
    logic [MW-1:0]        move_cnt;
    logic [PW-1:0]        exp_player;
    logic [PW-1:0]        scan_player;
    logic [RW-1:0]        run;
    logic [1:0]           dir;
    logic signed [SW-1:0] place_x, place_y;
    logic signed [SW-1:0] cur_x, cur_y;
    logic                 resp_err;
    logic [1:0]           resp_code;
    logic [PW-1:0]        winner_q;
    logic                 stop_q;

    logic                 accept;
    logic                 in_range;
    logic [CW-1:0]        acc_x, acc_y;
    logic [1:0]           acc_code;
    logic [PW-1:0]        next_player;
    logic signed [SW-1:0] step_x, step_y, nxt_x, nxt_y;
    logic                 nxt_inb, nxt_hit;
    logic [CW-1:0]        nxt_xi, nxt_yi;
    logic                 rd_inb;
    logic [CW-1:0]        rd_xi, rd_yi;

    assign bus.in_ready  = (state == IDLE) && !clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.move_done = (state == RESP);
    assign bus.move_err  = (state == RESP) && resp_err;
    assign bus.err_code  = (state == RESP) ? resp_code : 2'd0;
    assign bus.winner    = winner_q;
    assign bus.stop_game = stop_q;

    // Validate an offered move. The checks run in priority order: game over,
    // then bad player or coordinate, then occupied cell.
    always_comb begin
        in_range = ({1'b0, bus.in_x} < N_U) && ({1'b0, bus.in_y} < N_U);
        acc_x    = in_range ? bus.in_x : '0;
        acc_y    = in_range ? bus.in_y : '0;
        if (stop_q)
            acc_code = 2'd1;
        else if (!in_range || (bus.in_player != exp_player))
            acc_code = 2'd2;
        else if (board[acc_y][acc_x] != EMPTY)
            acc_code = 2'd3;
        else
            acc_code = 2'd0;
        next_player = (exp_player == LAST_PLAYER) ? '0 : exp_player + PW'(1);
    end

    // Find the neighbour of the walk head in the current direction and sense,
    // and check whether it belongs to the player who just moved.
    always_comb begin
        step_x = (dir == 2'd1) ? '0 : SW'(1);
        case (dir)
            2'd0:    step_y = '0;
            2'd3:    step_y = '1;
            default: step_y = SW'(1);
        endcase
        if (state == SCAN_NEG) begin
            step_x = -step_x;
            step_y = -step_y;
        end
        nxt_x   = cur_x + step_x;
        nxt_y   = cur_y + step_y;
        nxt_inb = !nxt_x[SW-1] && (nxt_x < N_S) && !nxt_y[SW-1] && (nxt_y < N_S);
        nxt_xi  = nxt_inb ? nxt_x[CW-1:0] : '0;
        nxt_yi  = nxt_inb ? nxt_y[CW-1:0] : '0;
        nxt_hit = nxt_inb && (board[nxt_yi][nxt_xi] == scan_player);
        rd_inb  = ({1'b0, rd_x} < N_U) && ({1'b0, rd_y} < N_U);
        rd_xi   = rd_inb ? rd_x : '0;
        rd_yi   = rd_inb ? rd_y : '0;
    end

    // Next-state logic. A full run ends the scan, and clear always wins.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept)
                    next_state = (acc_code == 2'd0) ? SCAN_POS : RESP;
            end
            SCAN_POS: begin
                if (run == RUN_K)
                    next_state = RESP;
                else if (!nxt_hit)
                    next_state = SCAN_NEG;
            end
            SCAN_NEG: begin
                if (run == RUN_K)
                    next_state = RESP;
                else if (!nxt_hit)
                    next_state = (dir == 2'd3) ? RESP : SCAN_POS;
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (clear)
            next_state = IDLE;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Board, turn tracking, scan datapath, game result and read port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    board[r][c] <= EMPTY;
            move_cnt    <= '0;
            exp_player  <= '0;
            scan_player <= '0;
            run         <= '0;
            dir         <= '0;
            place_x     <= '0;
            place_y     <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            resp_err    <= 1'b0;
            resp_code   <= 2'd0;
            winner_q    <= EMPTY;
            stop_q      <= 1'b0;
            rd_cell     <= EMPTY;
        end else if (clear) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    board[r][c] <= EMPTY;
            move_cnt    <= '0;
            exp_player  <= '0;
            scan_player <= '0;
            run         <= '0;
            dir         <= '0;
            place_x     <= '0;
            place_y     <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            resp_err    <= 1'b0;
            resp_code   <= 2'd0;
            winner_q    <= EMPTY;
            stop_q      <= 1'b0;
            rd_cell     <= EMPTY;
        end else begin
            rd_cell <= rd_inb ? board[rd_yi][rd_xi] : EMPTY;
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_err  <= (acc_code != 2'd0);
                        resp_code <= acc_code;
                        if (acc_code == 2'd0) begin
                            board[acc_y][acc_x] <= bus.in_player;
                            move_cnt    <= move_cnt + MW'(1);
                            exp_player  <= next_player;
                            scan_player <= bus.in_player;
                            place_x     <= SW'(acc_x);
                            place_y     <= SW'(acc_y);
                            cur_x       <= SW'(acc_x);
                            cur_y       <= SW'(acc_y);
                            run         <= RW'(1);
                            dir         <= 2'd0;
                        end
                    end
                end
                SCAN_POS: begin
                    if (run == RUN_K) begin
                        winner_q <= scan_player;
                        stop_q   <= 1'b1;
                    end else if (nxt_hit) begin
                        run   <= run + RW'(1);
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                    end else begin
                        cur_x <= place_x;
                        cur_y <= place_y;
                    end
                end
                SCAN_NEG: begin
                    if (run == RUN_K) begin
                        winner_q <= scan_player;
                        stop_q   <= 1'b1;
                    end else if (nxt_hit) begin
                        run   <= run + RW'(1);
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                    end else begin
                        cur_x <= place_x;
                        cur_y <= place_y;
                        run   <= RW'(1);
                        dir   <= dir + 2'd1;
                        if ((dir == 2'd3) && (move_cnt == CELLS))
                            stop_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mnk_game_engine.sv
// Directed testbench for mnk_game_engine. It uses a 5x5 K=4 instance for
// most scenarios and a 3x3 K=3 instance for the drawn game.
module tb_mnk_game_engine;
    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear5, clear3;
    logic [2:0] rd_x5, rd_y5;
    logic [1:0] rd_cell5;
    logic [1:0] rd_x3, rd_y3;
    logic [1:0] rd_cell3;
    int         checks = 0;
    int         errors = 0;

    mnk_game_engine_if #(.N(5), .PLAYERS(2)) bus5 ();
    mnk_game_engine_if #(.N(3), .PLAYERS(2)) bus3 ();

    mnk_game_engine #(.N(5), .K(4), .PLAYERS(2)) dut5 (
        .clk(clk), .reset_n(reset_n), .clear(clear5), .bus(bus5),
        .rd_x(rd_x5), .rd_y(rd_y5), .rd_cell(rd_cell5)
    );

    mnk_game_engine #(.N(3), .K(3), .PLAYERS(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .clear(clear3), .bus(bus3),
        .rd_x(rd_x3), .rd_y(rd_y3), .rd_cell(rd_cell3)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Offer one move on the selected engine and return just after acceptance.
    task automatic start_move(input int sel, input int x, input int y, input int p, output bit ok);
        int guard;
        ok = 1'b0;
        guard = 0;
        @(negedge clk);
        while ((((sel == 0) ? bus5.in_ready : bus3.in_ready) !== 1'b1) && (guard < 50)) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) return;
        if (sel == 0) begin
            bus5.in_x = 3'(x); bus5.in_y = 3'(y); bus5.in_player = 2'(p); bus5.in_valid = 1'b1;
        end else begin
            bus3.in_x = 2'(x); bus3.in_y = 2'(y); bus3.in_player = 2'(p); bus3.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b0;
        bus3.in_valid = 1'b0;
        ok = 1'b1;
    endtask

    // Wait a bounded number of cycles for move_done and capture the results.
    task automatic wait_done(input int sel, output logic err, output logic [1:0] code,
                             output logic [1:0] win, output logic stop, output int cyc, output bit got);
        got = 1'b0; cyc = 0; err = 1'bx; code = 2'bxx; win = 2'bxx; stop = 1'bx;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (((sel == 0) ? bus5.move_done : bus3.move_done) === 1'b1) begin
                err  = (sel == 0) ? bus5.move_err  : bus3.move_err;
                code = (sel == 0) ? bus5.err_code  : bus3.err_code;
                win  = (sel == 0) ? bus5.winner    : bus3.winner;
                stop = (sel == 0) ? bus5.stop_game : bus3.stop_game;
                got  = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_move(input int sel, input int x, input int y, input int p,
                           output logic err, output logic [1:0] code, output logic [1:0] win,
                           output logic stop, output int cyc, output bit got);
        bit ok;
        start_move(sel, x, y, p, ok);
        if (!ok) begin
            got = 1'b0; cyc = 0; err = 1'bx; code = 2'bxx; win = 2'bxx; stop = 1'bx;
            return;
        end
        wait_done(sel, err, code, win, stop, cyc, got);
    endtask

    task automatic pulse_clear(input int sel);
        @(negedge clk);
        if (sel == 0) clear5 = 1'b1; else clear3 = 1'b1;
        @(negedge clk);
        clear5 = 1'b0;
        clear3 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clear5 = 1'b0; clear3 = 1'b0;
        rd_x5 = '0; rd_y5 = '0; rd_x3 = '0; rd_y3 = '0;
        bus5.in_valid = 1'b0; bus5.in_x = '0; bus5.in_y = '0; bus5.in_player = '0;
        bus3.in_valid = 1'b0; bus3.in_x = '0; bus3.in_y = '0; bus3.in_player = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus5.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", bus5.in_ready); end
        checks++;
        if (bus5.winner !== 2'd3) begin errors++; $display("FAIL reset_winner: got %0d, required 3", bus5.winner); end
        checks++;
        if (bus5.stop_game !== 1'b0) begin errors++; $display("FAIL reset_stop: got %b, required 0", bus5.stop_game); end
        checks++;
        if (bus5.move_done !== 1'b0) begin errors++; $display("FAIL reset_move_done: got %b, required 0", bus5.move_done); end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                rd_x5 = 3'(x); rd_y5 = 3'(y);
                @(negedge clk);
                checks++;
                if (rd_cell5 !== 2'd3) begin errors++; $display("FAIL reset_cell(%0d,%0d): got %0d, required 3", x, y, rd_cell5); end
            end
        end
    endtask

    task automatic test_horizontal_win();
        int mx[7] = '{0, 0, 1, 1, 2, 2, 3};
        int my[7] = '{0, 1, 0, 1, 0, 1, 0};
        logic err, stop, exp_stop;
        logic [1:0] code, win, exp_win;
        int cyc;
        bit got;
        for (int i = 0; i < 7; i++) begin
            exp_win  = (i == 6) ? 2'd0 : 2'd3;
            exp_stop = (i == 6);
            do_move(0, mx[i], my[i], i % 2, err, code, win, stop, cyc, got);
            checks++;
            if (!got) begin
                errors++; $display("FAIL hwin_done[%0d]: no move_done, required within 40 cycles", i);
            end else if (err !== 1'b0 || win !== exp_win || stop !== exp_stop) begin
                errors++;
                $display("FAIL hwin_move[%0d]: err=%b winner=%0d stop=%b, required err=0 winner=%0d stop=%b",
                         i, err, win, stop, exp_win, exp_stop);
            end
        end
        do_move(0, 4, 4, 1, err, code, win, stop, cyc, got);
        checks++;
        if (!got || err !== 1'b1 || code !== 2'd1) begin
            errors++; $display("FAIL after_win_reject: got=%b err=%b code=%0d, required err=1 code=1", got, err, code);
        end
        checks++;
        if (bus5.winner !== 2'd0 || bus5.stop_game !== 1'b1) begin
            errors++; $display("FAIL win_hold: winner=%0d stop=%b, required 0 and 1", bus5.winner, bus5.stop_game);
        end
    endtask

    task automatic test_errors();
        int ex[6]  = '{0, 5, 2, 2, 3, 3};
        int ey[6]  = '{0, 0, 2, 2, 3, 3};
        int ep[6]  = '{1, 0, 0, 1, 0, 1};
        int eerr[6] = '{1, 1, 0, 1, 1, 0};
        int ecode[6] = '{2, 2, 0, 3, 2, 0};
        logic err, stop;
        logic [1:0] code, win;
        int cyc;
        bit got;
        pulse_clear(0);
        for (int i = 0; i < 6; i++) begin
            do_move(0, ex[i], ey[i], ep[i], err, code, win, stop, cyc, got);
            checks++;
            if (!got || err !== 1'(eerr[i]) || code !== 2'(ecode[i])) begin
                errors++;
                $display("FAIL err_case[%0d]: got=%b err=%b code=%0d, required err=%0d code=%0d",
                         i, got, err, code, eerr[i], ecode[i]);
            end
            if (i == 3) begin
                rd_x5 = 3'd2; rd_y5 = 3'd2;
                @(negedge clk);
                checks++;
                if (rd_cell5 !== 2'd0) begin errors++; $display("FAIL occupied_cell: got %0d, required 0", rd_cell5); end
            end
        end
    endtask

    task automatic test_anti_diag();
        int mx[7] = '{3, 4, 2, 4, 1, 4, 0};
        int my[7] = '{0, 4, 1, 3, 2, 2, 3};
        logic err, stop, exp_stop;
        logic [1:0] code, win, exp_win;
        int cyc;
        bit got;
        pulse_clear(0);
        for (int i = 0; i < 7; i++) begin
            exp_win  = (i == 6) ? 2'd0 : 2'd3;
            exp_stop = (i == 6);
            do_move(0, mx[i], my[i], i % 2, err, code, win, stop, cyc, got);
            checks++;
            if (!got || err !== 1'b0 || win !== exp_win || stop !== exp_stop) begin
                errors++;
                $display("FAIL adiag_move[%0d]: got=%b err=%b winner=%0d stop=%b, required err=0 winner=%0d stop=%b",
                         i, got, err, win, stop, exp_win, exp_stop);
            end
            if (i == 6) begin
                checks++;
                if (cyc > 26) begin errors++; $display("FAIL adiag_latency: %0d cycles, required <= 26", cyc); end
            end
        end
    endtask

    task automatic test_draw();
        int mx[9] = '{0, 2, 1, 0, 2, 1, 0, 1, 2};
        int my[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        logic err, stop, exp_stop;
        logic [1:0] code, win;
        int cyc;
        bit got;
        for (int i = 0; i < 9; i++) begin
            exp_stop = (i == 8);
            do_move(1, mx[i], my[i], i % 2, err, code, win, stop, cyc, got);
            checks++;
            if (!got || err !== 1'b0 || win !== 2'd3 || stop !== exp_stop) begin
                errors++;
                $display("FAIL draw_move[%0d]: got=%b err=%b winner=%0d stop=%b, required err=0 winner=3 stop=%b",
                         i, got, err, win, stop, exp_stop);
            end
        end
    endtask

    task automatic test_clear_during_scan();
        logic err, stop;
        logic [1:0] code, win;
        int cyc;
        bit got, ok, seen;
        pulse_clear(0);
        start_move(0, 2, 2, 0, ok);
        clear5 = 1'b1;
        #1;
        checks++;
        if (!ok || bus5.in_ready !== 1'b0) begin errors++; $display("FAIL clear_in_ready: ok=%b in_ready=%b, required 0", ok, bus5.in_ready); end
        @(posedge clk);
        #1;
        clear5 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus5.move_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL clear_no_done: move_done seen=1, required 0"); end
        for (int y = 0; y < 5; y++) begin
            for (int x = 0; x < 5; x++) begin
                rd_x5 = 3'(x); rd_y5 = 3'(y);
                @(negedge clk);
                checks++;
                if (rd_cell5 !== 2'd3) begin errors++; $display("FAIL clear_cell(%0d,%0d): got %0d, required 3", x, y, rd_cell5); end
            end
        end
        do_move(0, 1, 1, 0, err, code, win, stop, cyc, got);
        checks++;
        if (!got || err !== 1'b0 || stop !== 1'b0) begin
            errors++; $display("FAIL clear_new_game: got=%b err=%b stop=%b, required err=0 stop=0", got, err, stop);
        end
    endtask

    task automatic test_reset_during_scan();
        logic err, stop;
        logic [1:0] code, win;
        int cyc;
        bit got, ok, seen;
        pulse_clear(0);
        rd_x5 = 3'd1; rd_y5 = 3'd1;
        start_move(0, 1, 1, 0, ok);
        reset_n = 1'b0;
        #1;
        checks++;
        if (!ok || bus5.winner !== 2'd3 || bus5.stop_game !== 1'b0 || bus5.move_done !== 1'b0
            || bus5.in_ready !== 1'b1 || rd_cell5 !== 2'd3) begin
            errors++;
            $display("FAIL reset_in_scan: ok=%b winner=%0d stop=%b done=%b ready=%b cell=%0d, required 3 0 0 1 3",
                     ok, bus5.winner, bus5.stop_game, bus5.move_done, bus5.in_ready, rd_cell5);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus5.move_done === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen || rd_cell5 !== 2'd3) begin
            errors++; $display("FAIL reset_after_scan: done_seen=%b cell=%0d, required 0 and 3", seen, rd_cell5);
        end
        do_move(0, 0, 0, 0, err, code, win, stop, cyc, got);
        checks++;
        if (!got || err !== 1'b0) begin errors++; $display("FAIL reset_new_game: got=%b err=%b, required err=0", got, err); end
    endtask

    // Hard stop in case anything wedges the scenario sequence.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_horizontal_win();
        test_errors();
        test_anti_diag();
        test_draw();
        test_clear_during_scan();
        test_reset_during_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
